// File: rtl/plcounter_mod.sv
// Parameterised up/down counter with parallel load, sticky overflow/underflow flags and terminal count.
// Optional saturate mode is enabled by defining PLCOUNTER_MOD_SAT_EN; the default build always wraps.
module plcounter_mod #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAXVAL  = 2**WIDTH - 1,
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              updown,
    input  logic              sat,
    input  logic [WIDTH-1:0]  in,
    input  logic [STEP_W-1:0] step,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              unf
);

    if (64'(MAXVAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_maxval
        $error("MAXVAL does not fit in WIDTH bits");
    end
    if (RST_VAL > MAXVAL) begin : g_bad_rst_val
        $error("RST_VAL exceeds MAXVAL");
    end
    if (((64'd1 << STEP_W) - 64'd1) > (64'(MAXVAL) + 64'd1)) begin : g_bad_step_w
        $error("largest step exceeds the count modulus");
    end

    localparam logic [WIDTH:0]   MaxW  = (WIDTH+1)'(MAXVAL);
    localparam logic [WIDTH:0]   ModW  = (WIDTH+1)'(64'(MAXVAL) + 64'd1);
    localparam logic [WIDTH-1:0] MaxN  = WIDTH'(MAXVAL);
    localparam logic [WIDTH-1:0] RstN  = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ovf_evt, unf_evt;
    logic             sat_mode;

    // One guard bit so neither the sum nor the wrapped difference truncates.
    logic [WIDTH:0] cur, stp, up_sum, up_wrap, dn_diff, dn_wrap;

`ifdef PLCOUNTER_MOD_SAT_EN
    assign sat_mode = sat;
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign sat_mode   = 1'b0;
`endif

    assign cur     = {1'b0, cnt_q};
    assign stp     = (WIDTH+1)'(step);
    assign up_sum  = cur + stp;
    assign up_wrap = up_sum - ModW;
    assign dn_diff = cur - stp;
    assign dn_wrap = cur + ModW - stp;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (load) begin
            cnt_d = ({1'b0, in} > MaxW) ? MaxN : in;
        end else if (en) begin
            if (updown) begin
                if (up_sum > MaxW) begin
                    ovf_evt = 1'b1;
                    cnt_d   = sat_mode ? MaxN : up_wrap[WIDTH-1:0];
                end else begin
                    cnt_d = up_sum[WIDTH-1:0];
                end
            end else begin
                if (stp <= cur) begin
                    cnt_d = dn_diff[WIDTH-1:0];
                end else begin
                    unf_evt = 1'b1;
                    cnt_d   = sat_mode ? '0 : dn_wrap[WIDTH-1:0];
                end
            end
        end
    end

    // A fresh event wins over a coincident clear.
    assign ovf_d = ovf_evt | (ovf_q & ~clr);
    assign unf_d = unf_evt | (unf_q & ~clr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= RstN;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out = cnt_q;
    assign ovf = ovf_q;
    assign unf = unf_q;
    assign tc  = updown ? (cnt_q == MaxN) : (cnt_q == '0);

endmodule

// File: tb/tb_plcounter_mod.sv
// Self-checking bench for plcounter_mod (WIDTH=8, MAXVAL=99): integer reference model compared
// every cycle, plus directed literal checks. Saturation checks depend on PLCOUNTER_MOD_SAT_EN.
module tb_plcounter_mod;

    localparam int MAXV = 99;
    localparam int RSTV = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, load = 1'b0, updown = 1'b1, sat = 1'b0, clr = 1'b0;
    logic [7:0] in = '0;
    logic [3:0] step = '0;
    logic [7:0] out;
    logic       tc, ovf, unf;

    int n_checks = 0;
    int n_err    = 0;

    int m_out = 0;
    bit m_ovf = 0, m_unf = 0, mv = 0;

    plcounter_mod #(
        .WIDTH  (8),
        .MAXVAL (MAXV),
        .STEP_W (4),
        .RST_VAL(RSTV)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .updown(updown),
        .sat   (sat),
        .in    (in),
        .step  (step),
        .clr   (clr),
        .out   (out),
        .tc    (tc),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over the count range 0..MAXV.
    always @(posedge clk) begin
        int  nxt;
        bit  o, u, s;
`ifdef PLCOUNTER_MOD_SAT_EN
        s = sat;
`else
        s = 1'b0;
`endif
        if (!rst) begin
            m_out <= RSTV;
            m_ovf <= 1'b0;
            m_unf <= 1'b0;
            mv    <= 1'b1;
        end else begin
            nxt = m_out;
            o   = 1'b0;
            u   = 1'b0;
            if (load) begin
                nxt = (int'(in) > MAXV) ? MAXV : int'(in);
            end else if (en) begin
                if (updown) begin
                    if (m_out + int'(step) > MAXV) begin
                        o   = 1'b1;
                        nxt = s ? MAXV : m_out + int'(step) - (MAXV + 1);
                    end else begin
                        nxt = m_out + int'(step);
                    end
                end else begin
                    if (int'(step) > m_out) begin
                        u   = 1'b1;
                        nxt = s ? 0 : m_out + (MAXV + 1) - int'(step);
                    end else begin
                        nxt = m_out - int'(step);
                    end
                end
            end
            m_out <= nxt;
            m_ovf <= o | (m_ovf & ~clr);
            m_unf <= u | (m_unf & ~clr);
        end
    end

    always @(posedge clk) begin
        #1;
        if (mv) begin
            check("model_out", 32'(out), 32'(m_out));
            check("model_ovf", 32'(ovf), 32'(m_ovf));
            check("model_unf", 32'(unf), 32'(m_unf));
            check("model_tc",  32'(tc),  32'(updown ? (m_out == MAXV) : (m_out == 0)));
        end
    end

    // Apply inputs, then wait one edge; literal checks follow at posedge+2.
    task automatic cyc(input bit r, input bit l, input bit e, input bit ud, input bit s,
                       input bit c, input int d, input int st);
        rst = r; load = l; en = e; updown = ud; sat = s; clr = c;
        in = 8'(d); step = 4'(st);
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        check("rst_out", 32'(out), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_unf", 32'(unf), 0);
        check("rst_tc_up", 32'(tc), 0);
        updown = 1'b0;
        #1;
        check("rst_tc_down", 32'(tc), 1);

        // Count up by 3 to 99, then wrap to 2
        cyc(1, 0, 1, 1, 0, 0, 0, 3);
        check("up_first", 32'(out), 3);
        for (int i = 0; i < 32; i++) cyc(1, 0, 1, 1, 0, 0, 0, 3);
        check("up_99", 32'(out), 99);
        check("up_99_tc", 32'(tc), 1);
        check("up_99_ovf", 32'(ovf), 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 3);
        check("wrap_up_out", 32'(out), 2);
        check("wrap_up_ovf", 32'(ovf), 1);

        // Load clamp, and load beating en
        cyc(1, 1, 0, 1, 0, 0, 150, 0);
        check("load_clamp", 32'(out), 99);
        cyc(1, 1, 1, 1, 0, 0, 40, 5);
        check("load_over_en", 32'(out), 40);
        check("load_keeps_ovf", 32'(ovf), 1);

        // Down wrap, clr vs coincident underflow, clr alone
        cyc(1, 1, 0, 0, 0, 0, 4, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 7);
        check("wrap_dn_out", 32'(out), 97);
        check("wrap_dn_unf", 32'(unf), 1);
        cyc(1, 1, 0, 0, 0, 0, 3, 0);
        cyc(1, 0, 1, 0, 0, 1, 0, 7);
        check("clr_vs_unf_out", 32'(out), 96);
        check("clr_vs_unf", 32'(unf), 1);
        check("clr_ovf", 32'(ovf), 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0);
        check("clr_alone", 32'(unf), 0);

        // Reset mid-count beats load
        cyc(1, 1, 0, 1, 0, 0, 98, 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 5);
        cyc(1, 1, 0, 1, 0, 0, 57, 0);
        check("pre_rst_out", 32'(out), 57);
        check("pre_rst_ovf", 32'(ovf), 1);
        cyc(0, 1, 1, 1, 0, 1, 20, 3);
        check("mid_rst_out", 32'(out), RSTV);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_unf", 32'(unf), 0);
        cyc(1, 0, 1, 1, 0, 0, 0, 3);
        check("post_rst_first", 32'(out), RSTV + 3);

        // step=0 holds
        cyc(1, 1, 0, 1, 0, 0, 42, 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 1, i[0], 0, 0, 0, 0);
        check("step0_out", 32'(out), 42);
        check("step0_ovf", 32'(ovf), 0);
        check("step0_unf", 32'(unf), 0);

        // sat=1: saturates only when the feature is compiled in
        cyc(1, 1, 0, 1, 1, 0, 98, 0);
        cyc(1, 0, 1, 1, 1, 0, 0, 5);
`ifdef PLCOUNTER_MOD_SAT_EN
        check("sat_up_out", 32'(out), 99);
`else
        check("nosat_up_out", 32'(out), 3);
`endif
        check("sat_up_ovf", 32'(ovf), 1);
        cyc(1, 1, 0, 0, 1, 0, 2, 0);
        cyc(1, 0, 1, 0, 1, 0, 0, 7);
`ifdef PLCOUNTER_MOD_SAT_EN
        check("sat_dn_out", 32'(out), 0);
`else
        check("nosat_dn_out", 32'(out), 95);
`endif
        check("sat_dn_unf", 32'(unf), 1);
        cyc(1, 1, 0, 1, 1, 1, 99, 0);
        cyc(1, 0, 1, 1, 1, 0, 0, 15);
`ifdef PLCOUNTER_MOD_SAT_EN
        check("sat_at_max", 32'(out), 99);
`else
        check("wrap_at_max", 32'(out), 14);
`endif

        // Mixed stimulus, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 40) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/plcounter_mod.md
PLCOUNTER_MOD -- requirements
Module: plcounter_mod

Interface
REQ-001 Parameter WIDTH, default 8: counter and load-data width in bits.
REQ-002 Parameter MAXVAL, default 2**WIDTH-1: highest count value; count range is 0..MAXVAL (modulus MAXVAL+1).
REQ-003 Parameter STEP_W, default 4: step input width in bits.
REQ-004 Parameter RST_VAL, default 0: count value loaded on reset.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-007 en  input  1  count enable.
REQ-008 load  input  1  parallel load strobe.
REQ-009 updown  input  1  direction: 1 = up, 0 = down.
REQ-010 sat  input  1  mode: 1 = saturate, 0 = wrap (see Configuration).
REQ-011 in  input  WIDTH  parallel load value.
REQ-012 step  input  STEP_W  increment/decrement magnitude.
REQ-013 clr  input  1  clears the sticky flags.
REQ-014 out  output  WIDTH  registered count.
REQ-015 tc  output  1  terminal count, combinational from out and updown.
REQ-016 ovf  output  1  sticky overflow flag, registered.
REQ-017 unf  output  1  sticky underflow flag, registered.

Function
REQ-018 Per-edge priority SHALL be: reset, then load, then en; with none active, out holds.
REQ-019 Load: out <= in if in <= MAXVAL, else out <= MAXVAL; no flag is set on load; load beats en in the same cycle.
REQ-020 Up count (en=1, updown=1): if out+step <= MAXVAL, out <= out+step; else wrap mode gives out <= out+step-(MAXVAL+1) and saturate mode gives out <= MAXVAL; ovf set in both cases.
REQ-021 Down count (en=1, updown=0): if step <= out, out <= out-step; else wrap mode gives out <= out+(MAXVAL+1)-step and saturate mode gives out <= 0; unf set in both cases.
REQ-022 step=0 with en=1: out holds, no flag change.
REQ-023 Saturate at the bound: an up count at out=MAXVAL with step>0 keeps MAXVAL and sets ovf; a down count at out=0 with step>0 keeps 0 and sets unf.
REQ-024 Internal arithmetic SHALL be WIDTH+1 bits wide, so that no intermediate sum truncates.
REQ-025 tc = (out==MAXVAL) when updown=1, and (out==0) when updown=0, independent of en.
REQ-026 ovf/unf: once set, they hold until clr=1 is sampled; if clr coincides with a new overflow/underflow event, the set wins.
REQ-027 Count result SHALL be valid on out one cycle after the sampling edge (latency 1).
REQ-028 Elaboration SHALL fail if MAXVAL > 2**WIDTH-1, RST_VAL > MAXVAL or 2**STEP_W-1 > MAXVAL+1.

Reset
REQ-029 On a rising edge with rst=0: out <= RST_VAL, ovf <= 0 and unf <= 0, overriding load, en and clr.
REQ-030 Reset asserted mid-count SHALL take effect on that edge; the first count after release starts from RST_VAL.

Configuration
REQ-031 Macro PLCOUNTER_MOD_SAT_EN: when defined, the sat input selects saturate or wrap behaviour per REQ-020/021.
REQ-032 When PLCOUNTER_MOD_SAT_EN is undefined, the sat port still exists but is ignored, the block always wraps, and no saturation logic is synthesised.

Verification
REQ-033 WIDTH=8, MAXVAL=99: rst=0 for 1 edge, then en=1, updown=1, step=3 for 34 edges -> out sequence 0,3,...,99, then 2 (99+3-100) with ovf=1; tc=1 while out=99.
REQ-034 Load in=150 -> out=99; then load in=40 together with en=1 -> out=40, flags unchanged.
REQ-035 PLCOUNTER_MOD_SAT_EN defined, sat=1, out=98, up step=5 -> out=99, ovf=1; then down from out=2 with step=7 -> out=0, unf=1.
REQ-036 Wrap, down from out=4 with step=7 -> out=97, unf=1; then clr=1 together with another underflow -> unf stays 1; clr=1 alone -> unf=0.
REQ-037 Mid-count at out=57 with ovf=1, pull rst=0 for one edge together with load=1 -> out=RST_VAL (0), ovf=0, unf=0.
REQ-038 en=1, step=0 for 10 edges -> out constant, no flag change; macro undefined with sat=1 -> up past 99 wraps.
